// File: rtl/pic_pkg.sv
// Shared definitions for the 8259-style interrupt service path: OCW2 opcodes,
// acknowledge FSM encoding and small level helpers.
package pic_pkg;

  localparam int NUM_IR = 8;

  // OCW2 {R,SL,EOI}
  localparam logic [2:0] EOI_NONSPEC     = 3'b001;
  localparam logic [2:0] EOI_SPEC        = 3'b011;
  localparam logic [2:0] EOI_ROT_NONSPEC = 3'b101;
  localparam logic [2:0] EOI_ROT_SPEC    = 3'b111;
  localparam logic [2:0] SET_PRIO        = 3'b110;
  localparam logic [2:0] ROT_AEOI_SET    = 3'b100;
  localparam logic [2:0] ROT_AEOI_CLR    = 3'b000;
  localparam logic [2:0] EOI_NOP         = 3'b010;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PENDING = 2'd1;
  localparam state_t ST_ACK1    = 2'd2;

  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  // Lowest set bit wins; the resolver only ever presents one-hot values.
  function automatic logic [2:0] onehot_to_level(input logic [NUM_IR-1:0] v);
    logic [2:0] lvl;
    lvl = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (v[i]) lvl = 3'(i);
    end
    return lvl;
  endfunction

  function automatic logic [2:0] next_level(input logic [2:0] lvl);
    return lvl + 3'd1;
  endfunction

endpackage

// File: rtl/isr_highest_finder.sv
// Rotation-aware search for the highest-priority in-service level; priority
// starts at `rotate` and descends upward modulo 8.
module isr_highest_finder
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] isr,
  input  logic [2:0]        rotate,
  output logic [2:0]        level,
  output logic              found
);

  logic [2:0] idx;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    level = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      idx = rotate + 3'(i);
      if (isr[idx]) begin
        level = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_service_control.sv
// INT/INTA sequencing, ISR ownership and OCW2 EOI/rotate handling for an
// 8259-style controller. Auto-EOI support is built only when AUTO_EOI_EN is defined.
module interrupt_service_control
  import pic_pkg::*;
#(
  parameter int NUM_IR     = pic_pkg::NUM_IR,
  parameter int VEC_BASE_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IR-1:0]     interrupt_vector,
  input  logic                  inta_pulse,
  input  logic [VEC_BASE_W-1:0] vector_base,
  input  logic                  eoi_valid,
  input  logic [2:0]            eoi_op,
  input  logic [2:0]            eoi_level,
  input  logic                  aeoi_mode,
  output logic                  int_out,
  output logic [NUM_IR-1:0]     isr,
  output logic [2:0]            priority_rotate,
  output logic [NUM_IR-1:0]     clear_irr,
  output logic [VEC_BASE_W+2:0] data_out,
  output logic                  data_out_valid
);

  state_t      state;
  logic [2:0]  ack_level;

  logic [2:0]  fnd_level;
  logic        fnd_found;

  logic [NUM_IR-1:0] isr_clr;
  logic [NUM_IR-1:0] isr_set;
  logic [NUM_IR-1:0] isr_nxt;
  logic              eoi_rot_we;
  logic [2:0]        eoi_rot_val;
  logic              aeoi_rot_we;
  logic [2:0]        rot_nxt;

  logic ack1_fire;
  logic pend_fire;

  assign pend_fire = (state == ST_PENDING) && inta_pulse;
  assign ack1_fire = (state == ST_ACK1) && inta_pulse;

  isr_highest_finder u_finder (
    .isr    (isr),
    .rotate (priority_rotate),
    .level  (fnd_level),
    .found  (fnd_found)
  );

`ifdef AUTO_EOI_EN
  logic              rotate_in_aeoi;
  logic [NUM_IR-1:0] ack_vec;
`else
  logic unused_aeoi;
  assign unused_aeoi = aeoi_mode;
`endif

  // EOI decode: clear mask and explicit rotation request.
  always_comb begin
    isr_clr     = '0;
    eoi_rot_we  = 1'b0;
    eoi_rot_val = priority_rotate;
    if (eoi_valid) begin
      case (eoi_op)
        EOI_NONSPEC: begin
          if (fnd_found) isr_clr[fnd_level] = 1'b1;
        end
        EOI_ROT_NONSPEC: begin
          if (fnd_found) begin
            isr_clr[fnd_level] = 1'b1;
            eoi_rot_we         = 1'b1;
            eoi_rot_val        = next_level(fnd_level);
          end
        end
        EOI_SPEC: isr_clr[eoi_level] = 1'b1;
        EOI_ROT_SPEC: begin
          isr_clr[eoi_level] = 1'b1;
          eoi_rot_we         = 1'b1;
          eoi_rot_val        = next_level(eoi_level);
        end
        SET_PRIO: begin
          eoi_rot_we  = 1'b1;
          eoi_rot_val = next_level(eoi_level);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    aeoi_rot_we = 1'b0;
    isr_set     = pend_fire ? interrupt_vector : '0;
`ifdef AUTO_EOI_EN
    // A spurious acknowledge set no bit, so it has nothing to clear or rotate past.
    if (ack1_fire && aeoi_mode && (ack_vec != '0)) begin
      aeoi_rot_we = rotate_in_aeoi;
    end
`endif
  end

  always_comb begin
    isr_nxt = isr & ~isr_clr;
`ifdef AUTO_EOI_EN
    if (ack1_fire && aeoi_mode) isr_nxt = isr_nxt & ~ack_vec;
`endif
    // Clear before set: an INTA re-setting a just-EOI'd bit keeps it.
    isr_nxt = isr_nxt | isr_set;

    if (eoi_rot_we)       rot_nxt = eoi_rot_val;
    else if (aeoi_rot_we) rot_nxt = next_level(ack_level);
    else                  rot_nxt = priority_rotate;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      int_out         <= 1'b0;
      ack_level       <= '0;
      isr             <= '0;
      priority_rotate <= '0;
      clear_irr       <= '0;
      data_out        <= '0;
      data_out_valid  <= 1'b0;
    end else begin
      clear_irr       <= '0;
      data_out_valid  <= 1'b0;
      isr             <= isr_nxt;
      priority_rotate <= rot_nxt;
      case (state)
        ST_IDLE: begin
          if (interrupt_vector != '0) begin
            state   <= ST_PENDING;
            int_out <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (inta_pulse) begin
            state     <= ST_ACK1;
            int_out   <= 1'b0;
            clear_irr <= interrupt_vector;
            ack_level <= (interrupt_vector != '0) ? onehot_to_level(interrupt_vector)
                                                  : SPURIOUS_LEVEL;
          end
        end
        ST_ACK1: begin
          if (inta_pulse) begin
            state          <= ST_IDLE;
            data_out       <= {vector_base, ack_level};
            data_out_valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AUTO_EOI_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rotate_in_aeoi <= 1'b0;
      ack_vec        <= '0;
    end else begin
      if (pend_fire) ack_vec <= interrupt_vector;
      if (eoi_valid && (eoi_op == ROT_AEOI_SET)) rotate_in_aeoi <= 1'b1;
      if (eoi_valid && (eoi_op == ROT_AEOI_CLR)) rotate_in_aeoi <= 1'b0;
    end
  end
`endif

endmodule
